ising_energy_engine: RTL and testbench

Parametrised, handshaked successor to the team's σᵀJσ energy multiply-accumulate block. It streams the J matrix in column chunks over a valid/ready interface and accumulates the full Ising energy E = Σ_c s_c·(Σ_r s_r·J[r][c]), where s_i = +1 if sigma[i]=1 and −1 if sigma[i]=0. It supports signed or unsigned J, configurable columns per beat, and an optional early-abort against a threshold. It sits between the J-memory streamer and the annealing controller, and returns one energy result per start over a valid/ready result port.

---
 rtl/ising_energy_engine.sv | 143 ++++++++++++++
 tb/tb_ising_energy_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ising_energy_engine.sv
// rtl/ising_energy_engine.sv - streamed Ising energy accumulator
// Accumulates E = sum_c s_c * sum_r s_r * J[r][c] one J column chunk per accepted beat.
module ising_energy_engine #(
   parameter int VECTOR_SIZE     = 256,
   parameter int J_ELEMENT_WIDTH = 4,
   parameter int COLS_PER_CLK    = 4,
   parameter int J_SIGNED        = 0,
   parameter int ENERGY_WIDTH    = 2*$clog2(VECTOR_SIZE)+J_ELEMENT_WIDTH+1,
   parameter int NUM_CHUNKS      = VECTOR_SIZE/COLS_PER_CLK
) (
   input  logic                                               clk,
   input  logic                                               rst_n,
   input  logic                                               start,
   input  logic [VECTOR_SIZE-1:0]                             sigma,
   input  logic                                               abort_en,
   input  logic signed [ENERGY_WIDTH-1:0]                     energy_threshold,
   output logic                                               busy,
   input  logic                                               j_valid,
   output logic                                               j_ready,
   input  logic [VECTOR_SIZE*COLS_PER_CLK*J_ELEMENT_WIDTH-1:0] j_data,
   output logic [$clog2(NUM_CHUNKS)-1:0]                      j_chunk_idx,
   output logic                                               res_valid,
   input  logic                                               res_ready,
   output logic signed [ENERGY_WIDTH-1:0]                     res_energy,
   output logic                                               res_early,
   output logic [$clog2(NUM_CHUNKS):0]                        res_chunks
);

   localparam int N   = VECTOR_SIZE;
   localparam int W   = J_ELEMENT_WIDTH;
   localparam int C   = COLS_PER_CLK;
   localparam int EW  = ENERGY_WIDTH;
   localparam int LW  = $clog2(N);
   localparam int CIW = $clog2(NUM_CHUNKS);
   localparam int DW  = LW + W + 1;
   localparam int BW  = DW + $clog2(C) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state, state_next;
   logic [N-1:0]           sigma_q;
   logic                   abort_q;
   logic signed [EW-1:0]   thr_q;
   logic signed [EW-1:0]   acc, acc_next;
   logic [CIW-1:0]         chunk_idx;
   logic [CIW:0]           chunk_cnt;
   logic                   early_q;
   logic                   load, beat, last_chunk, abort_hit;

   logic [W-1:0]           elem;
   logic signed [DW-1:0]   elem_ext, dot;
   logic signed [BW-1:0]   dot_ext, block;
   logic [LW-1:0]          g_idx;

   // Column spins come from the global column index, not the local one.
   always_comb begin
      block    = '0;
      dot      = '0;
      dot_ext  = '0;
      elem     = '0;
      elem_ext = '0;
      g_idx    = '0;
      for (int c = 0; c < C; c++) begin
         dot = '0;
         for (int r = 0; r < N; r++) begin
            elem = j_data[(r*C+c)*W +: W];
            if (J_SIGNED != 0)
               elem_ext = DW'($signed(elem));
            else
               elem_ext = DW'($unsigned(elem));
            dot = sigma_q[r] ? dot + elem_ext : dot - elem_ext;
         end
         g_idx   = LW'(int'(chunk_idx) * C + c);
         dot_ext = BW'(dot);
         block   = sigma_q[g_idx] ? block + dot_ext : block - dot_ext;
      end
      acc_next = acc + EW'(block);
   end

   assign last_chunk = (chunk_idx == CIW'(NUM_CHUNKS-1));
   assign abort_hit  = !last_chunk && abort_q && (acc_next >= thr_q);

   always_comb begin
      state_next = state;
      load       = 1'b0;
      beat       = 1'b0;
      case (state)
         IDLE: if (start) begin
            load       = 1'b1;
            state_next = RUN;
         end
         RUN: if (j_valid) begin
            beat = 1'b1;
            if (last_chunk || abort_hit)
               state_next = DONE;
         end
         DONE: if (res_ready)
            state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sigma_q   <= '0;
         abort_q   <= 1'b0;
         thr_q     <= '0;
         acc       <= '0;
         chunk_idx <= '0;
         chunk_cnt <= '0;
         early_q   <= 1'b0;
      end else if (load) begin
         sigma_q   <= sigma;
         abort_q   <= abort_en;
         thr_q     <= energy_threshold;
         acc       <= '0;
         chunk_idx <= '0;
         chunk_cnt <= '0;
         early_q   <= 1'b0;
      end else if (beat) begin
         acc       <= acc_next;
         chunk_idx <= chunk_idx + CIW'(1);
         chunk_cnt <= chunk_cnt + (CIW+1)'(1);
         early_q   <= abort_hit;
      end
   end

   assign busy        = (state != IDLE);
   assign j_ready     = (state == RUN);
   assign res_valid   = (state == DONE);
   assign j_chunk_idx = chunk_idx;
   assign res_energy  = acc;
   assign res_early   = early_q;
   assign res_chunks  = chunk_cnt;

endmodule

// File: tb/tb_ising_energy_engine.sv
// tb/tb_ising_energy_engine.sv - self-checking bench for ising_energy_engine
// Runs an unsigned-J and a signed-J instance in lockstep against a chunk-level energy model.
module tb_ising_energy_engine;

   localparam int N  = 8;
   localparam int W  = 4;
   localparam int C  = 2;
   localparam int NC = N / C;
   localparam int EW = 2*$clog2(N)+W+1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n, start, abort_en, j_valid, res_ready;
   logic [N-1:0]         sigma;
   logic signed [EW-1:0] thr;
   logic [N*C*W-1:0]     j_data;
   logic [N*N*W-1:0]     jflat;

   logic                 u_busy, u_j_ready, u_res_valid, u_res_early;
   logic [1:0]           u_idx;
   logic [2:0]           u_chunks;
   logic signed [EW-1:0] u_energy;
   logic                 s_busy, s_j_ready, s_res_valid, s_res_early;
   logic [1:0]           s_idx;
   logic [2:0]           s_chunks;
   logic signed [EW-1:0] s_energy;

   int errors = 0;
   int checks = 0;
   int beats;
   bit exp_active = 1'b0;
   int exp_e [2];
   int exp_b [2];
   int exp_c [2];

   ising_energy_engine #(.VECTOR_SIZE(N), .J_ELEMENT_WIDTH(W), .COLS_PER_CLK(C), .J_SIGNED(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sigma(sigma), .abort_en(abort_en),
      .energy_threshold(thr), .busy(u_busy), .j_valid(j_valid), .j_ready(u_j_ready),
      .j_data(j_data), .j_chunk_idx(u_idx), .res_valid(u_res_valid), .res_ready(res_ready),
      .res_energy(u_energy), .res_early(u_res_early), .res_chunks(u_chunks));

   ising_energy_engine #(.VECTOR_SIZE(N), .J_ELEMENT_WIDTH(W), .COLS_PER_CLK(C), .J_SIGNED(1)) s_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sigma(sigma), .abort_en(abort_en),
      .energy_threshold(thr), .busy(s_busy), .j_valid(j_valid), .j_ready(s_j_ready),
      .j_data(j_data), .j_chunk_idx(s_idx), .res_valid(s_res_valid), .res_ready(res_ready),
      .res_energy(s_energy), .res_early(s_res_early), .res_chunks(s_chunks));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Streamer side: the chunk presented is the one after the beats already accepted.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         beats <= 0;
      else if (start && !u_busy)
         beats <= 0;
      else if (j_valid && u_j_ready)
         beats <= beats + 1;
   end

   always_comb begin
      j_data = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < C; c++)
            j_data[(r*C+c)*W +: W] = jflat[(r*N + (beats % NC)*C + c)*W +: W];
   end

   function automatic int jval(input int r, input int g, input bit sgn);
      int v;
      v = int'(jflat[(r*N+g)*W +: W]);
      if (sgn && v >= 8) v = v - 16;
      return v;
   endfunction

   function automatic void model(input logic [N-1:0] sg, input bit ab, input int th, input bit sgn,
                                 output int e, output int early, output int ch);
      int d;
      e = 0; early = 0; ch = 0;
      for (int k = 0; k < NC; k++) begin
         for (int cc = 0; cc < C; cc++) begin
            d = 0;
            for (int r = 0; r < N; r++)
               d += (sg[r] ? 1 : -1) * jval(r, k*C+cc, sgn);
            e += (sg[k*C+cc] ? 1 : -1) * d;
         end
         ch = k + 1;
         if (k == NC-1) return;
         if (ab && e >= th) begin
            early = 1;
            return;
         end
      end
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (u_res_valid) begin
            if (!exp_active) chk("u_spurious_valid", 1, 0);
            else begin
               chk("u_energy", int'(u_energy), exp_e[0]);
               chk("u_early", int'(u_res_early), exp_b[0]);
               chk("u_chunks", int'(u_chunks), exp_c[0]);
            end
         end
         if (s_res_valid) begin
            if (!exp_active) chk("s_spurious_valid", 1, 0);
            else begin
               chk("s_energy", int'(s_energy), exp_e[1]);
               chk("s_early", int'(s_res_early), exp_b[1]);
               chk("s_chunks", int'(s_chunks), exp_c[1]);
            end
         end
         if (u_j_ready) chk("u_chunk_idx", int'(u_idx), beats % NC);
         if (s_j_ready) chk("s_chunk_idx", int'(s_idx), beats % NC);
      end
   end

   task automatic set_j(input int mode);
      for (int i = 0; i < N*N; i++) begin
         case (mode)
            0:       jflat[i*W +: W] = 4'h1;
            1:       jflat[i*W +: W] = 4'hF;
            default: jflat[i*W +: W] = 4'(((i/N)*3 + (i%N)*5) % 16);
         endcase
      end
   endtask

   task automatic run_case(input logic [N-1:0] sg, input bit ab, input int th, input bit rnd,
                           input int hold, output int eu, output int es, output int ec,
                           output int eb, output int lat);
      model(sg, ab, th, 1'b0, exp_e[0], exp_b[0], exp_c[0]);
      model(sg, ab, th, 1'b1, exp_e[1], exp_b[1], exp_c[1]);
      @(negedge clk);
      exp_active = 1'b1;
      sigma = sg; abort_en = ab; thr = EW'(th); start = 1'b1; j_valid = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         start = rnd && ($urandom_range(0, 2) == 0);
         if (rnd) begin
            sigma    = ~sg;
            abort_en = ~ab;
            thr      = ~thr;
            j_valid  = 1'($urandom_range(0, 1));
         end
      end while (!u_res_valid && lat < 100);
      if (!u_res_valid) chk("result_timeout", 0, 1);
      eu = int'(u_energy); es = int'(s_energy);
      ec = int'(u_chunks); eb = int'(u_res_early);
      j_valid = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", int'(u_res_valid && s_res_valid), 1);
         start = rnd;
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0; start = 1'b0; exp_active = 1'b0;
      sigma = sg; abort_en = 1'b0; thr = '0;
      chk("idle_after_ack", int'(u_busy || s_busy), 0);
   endtask

   task automatic reset_values;
      chk("rst_busy", int'(u_busy || s_busy), 0);
      chk("rst_j_ready", int'(u_j_ready || s_j_ready), 0);
      chk("rst_idx", int'(u_idx) + int'(s_idx), 0);
      chk("rst_res_valid", int'(u_res_valid || s_res_valid), 0);
      chk("rst_energy_u", int'(u_energy), 0);
      chk("rst_energy_s", int'(s_energy), 0);
      chk("rst_early", int'(u_res_early || s_res_early), 0);
      chk("rst_chunks", int'(u_chunks) + int'(s_chunks), 0);
   endtask

   initial begin
      int eu, es, ec, eb, lat, k;
      rst_n = 1'b0; start = 1'b0; abort_en = 1'b0; j_valid = 1'b0; res_ready = 1'b0;
      sigma = '0; thr = '0;
      set_j(0);
      repeat (2) @(negedge clk);
      reset_values();
      rst_n = 1'b1;

      // all ones, all +1 spins
      run_case(8'hFF, 1'b0, 0, 1'b0, 0, eu, es, ec, eb, lat);
      chk("c1_energy_u", eu, 64);
      chk("c1_energy_s", es, 64);
      chk("c1_chunks", ec, 4);
      chk("c1_early", eb, 0);
      chk("c1_latency", lat, 5);

      run_case(8'h00, 1'b0, 0, 1'b0, 0, eu, es, ec, eb, lat);
      chk("c2_sigma00", eu, 64);
      run_case(8'h0F, 1'b0, 0, 1'b0, 1, eu, es, ec, eb, lat);
      chk("c2_sigma0F", eu, 0);

      set_j(1);
      run_case(8'hFF, 1'b0, 0, 1'b0, 0, eu, es, ec, eb, lat);
      chk("c3_unsigned_F", eu, 960);
      chk("c3_signed_F", es, -64);
      // negative threshold: signed partial -16 and unsigned 240 both abort
      run_case(8'hFF, 1'b1, -20, 1'b0, 0, eu, es, ec, eb, lat);
      chk("c3_neg_thr_u", eu, 240);
      chk("c3_neg_thr_s", es, -16);
      chk("c3_neg_thr_chunks", ec, 1);

      set_j(0);
      run_case(8'hFF, 1'b1, 10, 1'b0, 0, eu, es, ec, eb, lat);
      chk("c4_energy", eu, 16);
      chk("c4_chunks", ec, 1);
      chk("c4_early", eb, 1);
      chk("c4_latency", lat, 2);
      // threshold reached exactly on the last chunk: not an early result
      run_case(8'hFF, 1'b1, 64, 1'b0, 0, eu, es, ec, eb, lat);
      chk("c4_last_energy", eu, 64);
      chk("c4_last_chunks", ec, 4);
      chk("c4_last_early", eb, 0);

      run_case(8'hFF, 1'b0, 0, 1'b1, 3, eu, es, ec, eb, lat);
      chk("c5_stall_energy", eu, 64);
      chk("c5_stall_chunks", ec, 4);

      set_j(2);
      run_case(8'hA5, 1'b0, 0, 1'b0, 0, eu, es, ec, eb, lat);
      run_case(8'h3C, 1'b1, 0, 1'b1, 2, eu, es, ec, eb, lat);
      run_case(8'hC9, 1'b1, -30, 1'b0, 1, eu, es, ec, eb, lat);

      // reset in the middle of a run
      set_j(0);
      @(negedge clk);
      sigma = 8'hFF; abort_en = 1'b0; start = 1'b1; j_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         k++;
      end while (beats != 2 && k < 10);
      chk("c6_beats_before_reset", beats, 2);
      rst_n = 1'b0;
      #1;
      reset_values();
      j_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_case(8'hFF, 1'b0, 0, 1'b0, 0, eu, es, ec, eb, lat);
      chk("c6_energy_after_reset", eu, 64);
      chk("c6_latency_after_reset", lat, 5);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
